// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - Iterative AES block encryptor, one round per clock
// Optional feature: AES_ENC_FASTREADY_EN lets DONE accept the next block directly.

module aes_sbox (
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] w_sq;
   logic [7:0] w_inv;

   // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
   always_comb begin
      w_sq  = i_data;
      w_inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         w_sq  = gf_mul(w_sq, w_sq);
         w_inv = gf_mul(w_inv, w_sq);
      end
      o_data = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_encrypt_iter #(
   parameter int NR = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [127:0]            data_in,
   input  logic [128*(NR+1)-1:0]   round_keys,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [127:0]            data_out,
   output logic                    busy
);
   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   localparam logic [3:0] LP_NR = 4'(NR);

   state_t       r_fsm;
   state_t       w_fsm_nxt;
   logic [127:0] r_state;
   logic [127:0] w_state_nxt;
   logic [3:0]   r_rnd;
   logic [3:0]   w_rnd_nxt;
   logic         w_accept;
   logic         w_last;
   logic [127:0] w_key;
   logic [127:0] w_round;
   logic [127:0] w_sr_flat;
   logic [127:0] w_mc_flat;
   logic [7:0]   w_sb [16];
   logic [7:0]   w_sr [16];
   logic [7:0]   w_mc [16];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte k of the state sits at bits [127-8k -: 8]; byte index is row + 4*column.
   for (genvar k = 0; k < 16; k++) begin : g_sbox
      aes_sbox u_sbox (
         .i_data (r_state[127-8*k -: 8]),
         .o_data (w_sb[k])
      );
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
      end
      assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                         ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
   end

   for (genvar k = 0; k < 16; k++) begin : g_flat
      assign w_sr_flat[127-8*k -: 8] = w_sr[k];
      assign w_mc_flat[127-8*k -: 8] = w_mc[k];
   end

   // Keys are not latched; the live bus is indexed by the round counter.
   assign w_key    = round_keys[{r_rnd, 7'd0} +: 128];
   assign w_last   = (r_rnd == LP_NR);
   assign w_round  = (w_last ? w_sr_flat : w_mc_flat) ^ w_key;
   assign data_out = r_state;

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_state_nxt = r_state;
      w_rnd_nxt   = r_rnd;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      case (r_fsm)
         S_IDLE: in_ready = 1'b1;
         S_ROUND: begin
            busy        = 1'b1;
            w_state_nxt = w_round;
            if (w_last) w_fsm_nxt = S_DONE;
            else        w_rnd_nxt = r_rnd + 4'd1;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_fsm_nxt = S_IDLE;
`ifdef AES_ENC_FASTREADY_EN
               in_ready  = 1'b1;
`endif
            end
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
      w_accept = in_valid && in_ready;
      if (w_accept) begin
         w_state_nxt = data_in ^ round_keys[127:0];
         w_rnd_nxt   = 4'd1;
         w_fsm_nxt   = S_ROUND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm   <= S_IDLE;
         r_state <= '0;
         r_rnd   <= '0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_state <= w_state_nxt;
         r_rnd   <= w_rnd_nxt;
      end
   end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - Scoreboard bench for aes_encrypt_iter (NR=14 and NR=10)

module tb_aes_encrypt_iter;
`ifdef AES_ENC_FASTREADY_EN
   localparam int PERIOD = 15;
`else
   localparam int PERIOD = 16;
`endif

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic          in_valid14, in_ready14, out_valid14, out_ready14, busy14;
   logic [127:0]  data_in14, data_out14;
   logic [1919:0] keys14;
   logic          in_valid10, in_ready10, out_valid10, out_ready10, busy10;
   logic [127:0]  data_in10, data_out10;
   logic [1407:0] keys10;

   logic [7:0]   sbox_t [256];
   logic [127:0] exp14_q [$];
   int           acc14_q [$];
   logic [127:0] got14_q [$];
   int           gotc14_q [$];
   logic [127:0] exp10_q [$];
   int           acc10_q [$];
   logic [127:0] got10_q [$];
   int           gotc10_q [$];

   aes_encrypt_iter #(.NR(14)) u_dut14 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
      .data_in(data_in14), .round_keys(keys14), .out_valid(out_valid14),
      .out_ready(out_ready14), .data_out(data_out14), .busy(busy14));

   aes_encrypt_iter #(.NR(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
      .data_in(data_in10), .round_keys(keys10), .out_valid(out_valid10),
      .out_ready(out_ready10), .data_out(data_out10), .busy(busy10));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [1919:0] kexp(input logic [255:0] key, input int nk, input int nr);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] f;
      rc = 8'h01;
      f  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) f[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return f;
   endfunction

   function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] blk;
      blk = pt ^ rk[127:0];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int k = 0; k < 16; k++) s[k] = sbox_t[blk[127-8*k -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         if (rnd < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = t[k];
         blk = blk ^ rk[128*rnd +: 128];
      end
      return blk;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Accepts push the model's ciphertext; output transfers are recorded for the tests.
   initial forever begin
      @(negedge clk); #2;
      if (rst_n) begin
         if (in_valid14 && in_ready14) begin
            exp14_q.push_back(enc(data_in14, keys14, 14));
            acc14_q.push_back(cyc);
         end
         if (out_valid14 && out_ready14) begin
            got14_q.push_back(data_out14);
            gotc14_q.push_back(cyc);
         end
         if (in_valid10 && in_ready10) begin
            exp10_q.push_back(enc(data_in10, {512'h0, keys10}, 10));
            acc10_q.push_back(cyc);
         end
         if (out_valid10 && out_ready10) begin
            got10_q.push_back(data_out10);
            gotc10_q.push_back(cyc);
         end
      end
   end

   task automatic clear14();
      exp14_q.delete(); acc14_q.delete(); got14_q.delete(); gotc14_q.delete();
   endtask

   task automatic wait_got14(input int n, input int budget, output bit ok);
      int k = 0;
      while (got14_q.size() < n && k < budget) begin @(negedge clk); k++; end
      ok = (got14_q.size() >= n);
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      #2;
      checks++; if (in_ready14 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready14); end
      checks++; if (out_valid14 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid14); end
      checks++; if (busy14 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy14); end
      checks++; if (data_out14 !== 128'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out14); end
      checks++; if (in_ready10 !== 1'b1 || out_valid10 !== 1'b0) begin failures++; $display("FAIL reset_nr10 got=%b%b exp=10", in_ready10, out_valid10); end
      @(negedge clk); rst_n = 1;
      @(negedge clk); #2;
      checks++; if (in_ready14 !== 1'b1 || busy14 !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=10", in_ready14, busy14); end
   endtask

   task automatic test_vector14();
      bit ok;
      clear14(); out_ready14 = 1;
      @(negedge clk); in_valid14 = 1; data_in14 = 128'h00112233445566778899aabbccddeeff;
      @(negedge clk); in_valid14 = 0;
      wait_got14(1, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL vec14_timeout got=%0d exp=1", got14_q.size()); end
      else begin
         checks++; if (got14_q[0] !== 128'h8ea2b7ca516745bfeafc49904b496089) begin failures++; $display("FAIL vec14_data got=%h exp=8ea2b7ca516745bfeafc49904b496089", got14_q[0]); end
         checks++; if (got14_q[0] !== exp14_q[0]) begin failures++; $display("FAIL vec14_model got=%h exp=%h", got14_q[0], exp14_q[0]); end
         checks++; if (gotc14_q[0] - acc14_q[0] != 15) begin failures++; $display("FAIL vec14_latency got=%0d exp=15", gotc14_q[0] - acc14_q[0]); end
      end
   endtask

   task automatic test_vector10();
      int k = 0;
      out_ready10 = 1;
      @(negedge clk); in_valid10 = 1; data_in10 = 128'h00112233445566778899aabbccddeeff;
      @(negedge clk); in_valid10 = 0;
      while (got10_q.size() < 1 && k < 30) begin @(negedge clk); k++; end
      checks++;
      if (got10_q.size() < 1) begin failures++; $display("FAIL vec10_timeout got=0 exp=1"); end
      else begin
         checks++; if (got10_q[0] !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin failures++; $display("FAIL vec10_data got=%h exp=69c4e0d86a7b0430d8cdb78070b4c55a", got10_q[0]); end
         checks++; if (got10_q[0] !== exp10_q[0]) begin failures++; $display("FAIL vec10_model got=%h exp=%h", got10_q[0], exp10_q[0]); end
         checks++; if (gotc10_q[0] - acc10_q[0] != 11) begin failures++; $display("FAIL vec10_latency got=%0d exp=11", gotc10_q[0] - acc10_q[0]); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] pt, exp_d;
      int k = 0;
      clear14(); out_ready14 = 0;
      pt = rnd128(); exp_d = enc(pt, keys14, 14);
      @(negedge clk); in_valid14 = 1; data_in14 = pt;
      @(negedge clk); in_valid14 = 0;
      do begin @(negedge clk); #2; k++; end while (!out_valid14 && k < 40);
      checks++;
      if (!out_valid14) begin failures++; $display("FAIL bp_timeout got=0 exp=1"); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #2;
         checks++; if (out_valid14 !== 1'b1) begin failures++; $display("FAIL bp_valid_hold got=%b exp=1", out_valid14); end
         checks++; if (data_out14 !== exp_d) begin failures++; $display("FAIL bp_data_hold got=%h exp=%h", data_out14, exp_d); end
         checks++; if (in_ready14 !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready14); end
      end
      @(negedge clk); out_ready14 = 1;
      repeat (4) @(negedge clk);
      #2;
      checks++; if (got14_q.size() != 1) begin failures++; $display("FAIL bp_transfers got=%0d exp=1", got14_q.size()); end
      else begin
         checks++; if (got14_q[0] !== exp_d) begin failures++; $display("FAIL bp_data got=%h exp=%h", got14_q[0], exp_d); end
      end
      checks++; if (out_valid14 !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid14); end
   endtask

   task automatic test_busy_input();
      logic [127:0] pt, exp_d;
      bit ok;
      clear14(); out_ready14 = 1;
      pt = rnd128(); exp_d = enc(pt, keys14, 14);
      @(negedge clk); in_valid14 = 1; data_in14 = pt;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         in_valid14 = ($urandom_range(0, 1) != 0);
         data_in14  = rnd128();
         #2;
         checks++; if (busy14 !== 1'b1 || in_ready14 !== 1'b0) begin failures++; $display("FAIL busy_flags got=%b%b exp=10", busy14, in_ready14); end
      end
      @(negedge clk); in_valid14 = 0;
      wait_got14(1, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL busy_timeout got=0 exp=1"); end
      else begin
         checks++; if (exp14_q.size() != 1) begin failures++; $display("FAIL busy_accepts got=%0d exp=1", exp14_q.size()); end
         checks++; if (got14_q[0] !== exp_d) begin failures++; $display("FAIL busy_data got=%h exp=%h", got14_q[0], exp_d); end
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] pt2;
      bit ok;
      clear14(); out_ready14 = 1;
      @(negedge clk); in_valid14 = 1; data_in14 = rnd128();
      @(negedge clk); in_valid14 = 0;
      repeat (6) @(negedge clk);
      rst_n = 0;
      #2;
      checks++; if (in_ready14 !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready14); end
      checks++; if (out_valid14 !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid14); end
      checks++; if (busy14 !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy14); end
      checks++; if (data_out14 !== 128'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", data_out14); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      clear14();
      repeat (25) @(negedge clk);
      checks++; if (got14_q.size() != 0) begin failures++; $display("FAIL mid_rst_spurious got=%0d exp=0", got14_q.size()); end
      pt2 = rnd128();
      @(negedge clk); in_valid14 = 1; data_in14 = pt2;
      @(negedge clk); in_valid14 = 0;
      wait_got14(1, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL mid_rst_timeout got=0 exp=1"); end
      else begin
         checks++; if (got14_q[0] !== enc(pt2, keys14, 14)) begin failures++; $display("FAIL mid_rst_data_after got=%h exp=%h", got14_q[0], enc(pt2, keys14, 14)); end
         checks++; if (gotc14_q[0] - acc14_q[0] != 15) begin failures++; $display("FAIL mid_rst_latency got=%0d exp=15", gotc14_q[0] - acc14_q[0]); end
      end
   endtask

   task automatic test_back_to_back();
      int  k = 0;
      bit  ok;
      clear14(); out_ready14 = 1;
      while (k < 200) begin
         @(negedge clk);
         if (acc14_q.size() >= 4) break;
         in_valid14 = 1; data_in14 = rnd128();
         k++;
      end
      in_valid14 = 0;
      wait_got14(4, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d exp=4", got14_q.size()); end
      else begin
         checks++; if (exp14_q.size() != 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", exp14_q.size()); end
         for (int i = 0; i < 4; i++) begin
            checks++; if (got14_q[i] !== exp14_q[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got14_q[i], exp14_q[i]); end
            checks++; if (gotc14_q[i] - acc14_q[i] != 15) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=15", i, gotc14_q[i] - acc14_q[i]); end
         end
         for (int i = 1; i < 4; i++) begin
            checks++; if (gotc14_q[i] - gotc14_q[i-1] != PERIOD) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=%0d", i, gotc14_q[i] - gotc14_q[i-1], PERIOD); end
         end
      end
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [2047:0] tab;
      logic [1919:0] k10;
      tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
             128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
             128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
             128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
             128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
             128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
             128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
             128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int i = 0; i < 256; i++) sbox_t[i] = tab[2047-8*i -: 8];
      rst_n = 0;
      in_valid14 = 0; data_in14 = '0; out_ready14 = 1;
      in_valid10 = 0; data_in10 = '0; out_ready10 = 1;
      keys14 = kexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
      k10    = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
      keys10 = k10[1407:0];
      test_reset();
      test_vector14();
      test_vector10();
      test_backpressure();
      test_busy_input();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES block encryptor and the forward-direction companion to the unrolled decryptor. It takes one 128-bit plaintext block through a valid/ready handshake and computes one round per clock from a shared round datapath. It emits the ciphertext through a valid/ready handshake. Round keys are pre-expanded by the key schedule and presented on a flat bus, in the same key ordering the decryptor consumes in reverse.

## Interface
- NR, default 14: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256).
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- in_valid  in  1: plaintext block offered.
- in_ready  out  1: block can accept plaintext.
- data_in  in  128: plaintext. Bits [127:120] are FIPS byte 0; the state is column-major.
- round_keys  in  128*(NR+1): key i occupies bits [128*i+127 : 128*i]. Key 0 is the whitening key.
- out_valid  out  1: ciphertext available.
- out_ready  in  1: consumer accepts ciphertext.
- data_out  out  128: ciphertext, same byte order as data_in.
- busy  out  1: high in the ROUND state.

## Operation
- FSM states: IDLE, ROUND, DONE.
- Registers:
  - state_q, 128 bits.
  - rnd_q, 4 bits.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: state_q <= data_in ^ key[0], rnd_q <= 1, go to ROUND.
- ROUND, when rnd_q < NR:
  - state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ key[rnd_q].
  - rnd_q <= rnd_q + 1.
- ROUND, when rnd_q == NR:
  - state_q <= ShiftRows(SubBytes(state_q)) ^ key[NR]. This is the final round with no MixColumns.
  - Go to DONE.
- DONE:
  - out_valid = 1 and data_out = state_q.
  - On out_ready, go to IDLE.
- SubBytes uses 16 instances of the team's combinational forward S-box cell aes_sbox (8 bits in, 8 bits out).
- ShiftRows is wiring only.
- MixColumns is inline, using GF(2^8) xtime with polynomial 0x11B.
- round_keys is not latched. It is indexed live by rnd_q, so it must be held stable from the accept edge through the final-round edge. Behaviour with changing keys in that window is undefined.
- in_valid outside IDLE is ignored, and data_in is not sampled.
- out_ready outside DONE is ignored.
- data_out is driven from state_q at all times and is meaningful only while out_valid = 1.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
  - State register is IDLE; rnd_q = 0.
- Latency: if the accept edge is E0, round r is registered at edge Er, and out_valid rises after edge E_NR. That is NR+1 edges in total, or 15 for NR = 14.
- Throughput without the macro: one block per NR+2 cycles at minimum (IDLE, NR ROUND cycles, DONE). Any out_ready stall adds cycles.
- Backpressure: while out_valid=1 && out_ready=0, data_out and out_valid hold and in_ready stays 0.
- Reset mid-operation: the block returns to IDLE immediately, the in-flight block is discarded and no out_valid is produced.
- Simultaneous out_ready in DONE and in_valid high: without the macro, in_valid is not accepted until the following IDLE cycle.

## Configuration
- AES_ENC_FASTREADY_EN defined:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - An accept in DONE loads data_in ^ key[0] and goes directly to ROUND, giving one block per NR+1 cycles.
- AES_ENC_FASTREADY_EN undefined: in_ready = (state == IDLE) only, as described above.
- All other behaviour is identical either way.

## Test plan
- Single-block latency and result:
  - Stimulus: NR=14, plaintext 00112233445566778899aabbccddeeff, key 000102…1f (round keys from the bench model), out_ready=1.
  - Required: data_out = 8ea2b7ca516745bfeafc49904b496089, with out_valid rising after the 15th edge from accept.
- NR=10 vector:
  - Stimulus: same plaintext, key 000102…0f.
  - Required: data_out = 69c4e0d86a7b0430d8cdb78070b4c55a after 11 edges.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_valid and data_out stable, in_ready=0, with exactly one transfer when out_ready rises.
- Busy-period input:
  - Stimulus: toggle in_valid with random data_in during ROUND.
  - Required: no effect, and the ciphertext equals the original block's.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at rnd_q=7, then release.
  - Required: all outputs at reset values, no spurious out_valid, and the next block encrypts correctly.
- Macro on, back-to-back blocks:
  - Stimulus: in_valid and out_ready held at 1.
  - Required: out_valid pulses every 15 cycles for NR=14, each ciphertext matching the bench model. With the macro off, the pulses come every 16 cycles.
